// File: rtl/button_conditioner.sv
// Button front end: synchronise, debounce and edge-detect five active-low buttons.
// Adds hold-to-repeat on the four directions and a fixed-priority one-hot arbiter.
// Outputs are registered, active-low, single-cycle command pulses.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic btn_up_n,
  input  logic btn_down_n,
  input  logic btn_left_n,
  input  logic btn_right_n,
  input  logic btn_place_n,
  output logic move_up,
  output logic move_down,
  output logic move_left,
  output logic move_right,
  output logic place
);

  // Bit order everywhere: 0 up, 1 down, 2 left, 3 right, 4 place (also the priority order).
  localparam int unsigned NumBtn = 5;
  localparam int unsigned NumDir = 4;

  localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RptMax = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned RptW   = (RptMax > 1) ? $clog2(RptMax) : 1;

  localparam logic [DbW-1:0]  DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DbW-1:0]  DbOne    = DbW'(1);
  localparam logic [RptW-1:0] HoldLast = RptW'(HOLD_CYCLES - 1);
  localparam logic [RptW-1:0] RptLast  = RptW'(REPEAT_CYCLES - 1);
  localparam logic [RptW-1:0] RptOne   = RptW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StRepeat
  } rpt_state_e;

  logic [NumBtn-1:0] w_btn_n;
  logic [NumBtn-1:0] r_sync1;
  logic [NumBtn-1:0] r_sync2;
  logic [NumBtn-1:0] r_deb;
  logic [NumBtn-1:0] w_deb_d;
  logic [NumBtn-1:0] r_deb_prev;
  logic [DbW-1:0]    r_db_cnt    [NumBtn];
  logic [DbW-1:0]    w_db_cnt_d  [NumBtn];
  logic [NumBtn-1:0] w_press;

  rpt_state_e        r_state     [NumDir];
  rpt_state_e        w_state_d   [NumDir];
  logic [RptW-1:0]   r_rpt_cnt   [NumDir];
  logic [RptW-1:0]   w_rpt_cnt_d [NumDir];

  logic [NumBtn-1:0] w_req;
  logic [NumBtn-1:0] w_grant;
  logic [NumBtn-1:0] r_out_n;

  assign w_btn_n = {btn_place_n, btn_right_n, btn_left_n, btn_down_n, btn_up_n};

  // Two-flop synchroniser for the asynchronous raw buttons.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= w_btn_n;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES edges.
  always_comb begin
    w_deb_d = r_deb;
    for (int i = 0; i < NumBtn; i++) begin
      w_db_cnt_d[i] = '0;
      if (r_sync2[i] != r_deb[i]) begin
        if (r_db_cnt[i] == DbLast) begin
          w_deb_d[i] = r_sync2[i];
        end else begin
          w_db_cnt_d[i] = r_db_cnt[i] + DbOne;
        end
      end
    end
  end

  // Debounced level, its previous value for edge detection, and the stability counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_deb      <= '1;
      r_deb_prev <= '1;
      for (int i = 0; i < NumBtn; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      r_deb      <= w_deb_d;
      r_deb_prev <= r_deb;
      for (int i = 0; i < NumBtn; i++) begin
        r_db_cnt[i] <= w_db_cnt_d[i];
      end
    end
  end

  // Press is the debounced 1->0 transition; release produces nothing.
  assign w_press = r_deb_prev & ~r_deb;

  // Repeat FSM state and interval counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NumDir; i++) begin
        r_state[i]   <= StIdle;
        r_rpt_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumDir; i++) begin
        r_state[i]   <= w_state_d[i];
        r_rpt_cnt[i] <= w_rpt_cnt_d[i];
      end
    end
  end

  // Repeat FSM next state: a released button always drops straight back to idle.
  always_comb begin
    for (int i = 0; i < NumDir; i++) begin
      w_state_d[i]   = r_state[i];
      w_rpt_cnt_d[i] = r_rpt_cnt[i] + RptOne;
      if (r_deb[i]) begin
        w_state_d[i]   = StIdle;
        w_rpt_cnt_d[i] = '0;
      end else begin
        unique case (r_state[i])
          StIdle: begin
            w_rpt_cnt_d[i] = '0;
            if (w_press[i]) begin
              w_state_d[i] = StHold;
            end
          end
          StHold: begin
            if (r_rpt_cnt[i] == HoldLast) begin
              w_state_d[i]   = StRepeat;
              w_rpt_cnt_d[i] = '0;
            end
          end
          StRepeat: begin
            if (r_rpt_cnt[i] == RptLast) begin
              w_rpt_cnt_d[i] = '0;
            end
          end
          default: begin
            w_state_d[i]   = StIdle;
            w_rpt_cnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  // Repeat FSM outputs: command requests; place only ever requests on its press edge.
  always_comb begin
    w_req = '0;
    for (int i = 0; i < NumDir; i++) begin
      if (!r_deb[i]) begin
        unique case (r_state[i])
          StIdle:   w_req[i] = w_press[i];
          StHold:   w_req[i] = (r_rpt_cnt[i] == HoldLast);
          StRepeat: w_req[i] = (r_rpt_cnt[i] == RptLast);
          default:  w_req[i] = 1'b0;
        endcase
      end
    end
    w_req[NumBtn-1] = w_press[NumBtn-1];
  end

  // Fixed-priority arbiter: lowest index wins, losers are simply dropped.
  always_comb begin
    w_grant = '0;
    if (w_req[0]) begin
      w_grant[0] = 1'b1;
    end else if (w_req[1]) begin
      w_grant[1] = 1'b1;
    end else if (w_req[2]) begin
      w_grant[2] = 1'b1;
    end else if (w_req[3]) begin
      w_grant[3] = 1'b1;
    end else if (w_req[4]) begin
      w_grant[4] = 1'b1;
    end
  end

  // Registered active-low pulses; enable only masks the winner, state keeps running.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_n <= '1;
    end else begin
      r_out_n <= ~(w_grant & {NumBtn{enable}});
    end
  end

  assign move_up    = r_out_n[0];
  assign move_down  = r_out_n[1];
  assign move_left  = r_out_n[2];
  assign move_right = r_out_n[3];
  assign place      = r_out_n[4];

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front end of the cursor path: takes the five raw, bouncing, asynchronous active-low push-buttons from the board and produces clean single-cycle active-low command pulses for the cursor controller (`move_up`, `move_down`, `move_left`, `move_right`) and for ship placement (`place`). Each button is synchronised, debounced and edge-detected, and the four direction buttons have hold-to-repeat. An arbiter guarantees at most one command pulse per cycle. The cursor controller samples on the falling edge of `clk`, so every pulse is exactly one full `clk` period wide.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles before a level change is accepted (10 ms at 50 MHz); minimum 1.
- `HOLD_CYCLES`, default 25000000: cycles from the initial press pulse to the first repeat pulse.
- `REPEAT_CYCLES`, default 10000000: cycles between subsequent repeat pulses.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: 1 lets pulses out; 0 forces all outputs inactive. Debounce and repeat state keeps running while low.
- `btn_up_n`, `btn_down_n`, `btn_left_n`, `btn_right_n`, `btn_place_n` in 1 each: raw asynchronous buttons, 0 = pressed.
- `move_up`, `move_down`, `move_left`, `move_right` out 1 each: registered, 0 for exactly one cycle per command.
- `place` out 1: registered, 0 for exactly one cycle per press.

## Operation
- **Reset:** while `rst`=1 at a rising edge:
  - all outputs go to 1;
  - synchroniser flops and debounced levels go to 1 (released);
  - all counters clear to 0;
  - all repeat FSMs go to IDLE.
- **Synchroniser:** each button passes through a 2-flop synchroniser; `s` is the second-stage output.
- **Debounce:** per button, a counter sized with `$clog2(DEBOUNCE_CYCLES+1)` bits.
  - If `s` equals the debounced level `d`, the counter clears.
  - Otherwise the counter increments. When the increment would reach `DEBOUNCE_CYCLES`, `d` takes `s` and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `d`.
- **Press event:** `d` goes from 1 to 0. Release (`d` 0 to 1) produces no event.
- **Repeat FSM:** one per direction button; `place` never repeats. States IDLE, HOLD, REPEAT.
  - IDLE to HOLD on a press event; this issues a request and loads the counter with 0.
  - In HOLD, when the counter reaches `HOLD_CYCLES-1`: issue a request and go to REPEAT with the counter at 0.
  - In REPEAT, every time the counter reaches `REPEAT_CYCLES-1`: issue a request and restart the count.
  - From any state, `d`=1 returns the FSM to IDLE immediately, with no request that cycle.
  - Counter width is `$clog2` of the larger of `HOLD_CYCLES` and `REPEAT_CYCLES`.
- **Arbiter:** when several requests occur in the same cycle, the fixed priority is up > down > left > right > place.
  - Only the winner is pulsed; losers are dropped, not queued.
  - A held button's next repeat is unaffected by losing.
- **Enable gating:** with `enable`=0, winners are discarded, all outputs stay 1, and the FSMs and counters advance normally.
  - Re-enabling during a hold produces the next scheduled repeat, not an extra press pulse.

## Timing
- Edge numbering: edge 1 is the first rising edge that samples a raw button at 0, assuming it stays low.
  - `s`=0 after edge 2.
  - `d`=0 after edge `DEBOUNCE_CYCLES`+2.
  - The output is 0 for the one cycle after edge `DEBOUNCE_CYCLES`+3.
  - Total press-to-pulse latency is `DEBOUNCE_CYCLES`+3 edges.
- First repeat: the output is low `HOLD_CYCLES` cycles after the initial pulse.
- Further repeats: every `REPEAT_CYCLES` cycles after that.
- Release latency: `DEBOUNCE_CYCLES`+2 edges. Any repeat falling due before `d` rises is still issued.
- Back-to-back pulses on the same output cannot occur, because `REPEAT_CYCLES` ≥ 2 is required.
- Reset while a button is held:
  - all outputs are 1 at the next edge;
  - after `rst` falls, the held button is treated as a fresh press;
  - one pulse follows `DEBOUNCE_CYCLES`+3 edges after the first non-reset edge.
- Outputs never glitch; every output is a flop driven from `clk`.

## Test plan
Test parameters: `DEBOUNCE_CYCLES`=4, `HOLD_CYCLES`=10, `REPEAT_CYCLES`=5.
- **Clean press:**
  - Stimulus: reset 3 cycles, then hold `btn_left_n`=0 for 8 cycles and release.
  - Required response: `move_left`=0 for exactly one cycle, after edge 7; no other output moves; no pulse on release.
- **Bounce rejection:**
  - Stimulus: toggle `btn_up_n` 0/1 every 2 cycles for 20 cycles, then hold 0.
  - Required response: no pulse during the toggling; exactly one `move_up` pulse 7 edges after the stable 0 begins.
- **Auto-repeat:**
  - Stimulus: hold `btn_right_n`=0 for 40 cycles.
  - Required response: `move_right` pulses at cycles T, T+10, T+15, T+20, …, stopping once release is debounced; `btn_place_n` held the same way gives exactly one `place` pulse.
- **Simultaneous press:**
  - Stimulus: drive `btn_down_n` and `btn_right_n` to 0 on the same edge.
  - Required response: initial cycle gives only `move_down`; the same holds on every later coincident repeat.
- **Enable gating:**
  - Stimulus: hold `btn_up_n` with `enable`=0 during the initial and first repeat pulses, then set `enable`=1.
  - Required response: no output while disabled; the next pulse lands exactly on the 5-cycle repeat grid.
- **Reset mid-hold:**
  - Stimulus: assert `rst` for 2 cycles while `btn_down_n` is held in REPEAT.
  - Required response: outputs 1 during reset; after release, one `move_down` pulse 7 edges later, then repeats resume 10 cycles after it.
